// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BTB with 2-bit counters,
// combinational lookup, decode-driven update port and branch/mispredict counters.
package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
endpackage

module branch_predictor
    import rv32i_types::*;
#(
    parameter int IDX_WIDTH = 5,
    parameter int TAG_WIDTH = 30 - IDX_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_pc_i,
    output logic        IF_pred_taken_o,
    output logic [31:0] IF_pred_target_o,
    input  logic        ID_update_i,
    input  logic        ID_stall_i,
    input  rv32i_opcode ID_opcode_i,
    input  logic [31:0] ID_pc_i,
    input  logic        ID_pred_i,
    input  logic        ID_taken_i,
    input  logic [31:0] ID_target_i,
    output logic [31:0] br_count_o,
    output logic [31:0] mispred_count_o
);
    localparam int ENTRIES = 1 << IDX_WIDTH;

    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   is_jal_q;
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];
    logic [31:0]          br_cnt_q, br_cnt_d;
    logic [31:0]          mis_cnt_q, mis_cnt_d;

    logic [IDX_WIDTH-1:0] if_idx, id_idx;
    logic [TAG_WIDTH-1:0] if_tag, id_tag;
    logic                 if_hit, id_hit;

    assign if_idx = IF_pc_i[IDX_WIDTH+1:2];
    assign if_tag = IF_pc_i[31:IDX_WIDTH+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    always_comb begin
        IF_pred_taken_o  = if_hit & (is_jal_q[if_idx] | ctr_q[if_idx][1]);
        IF_pred_target_o = IF_pred_taken_o ? target_q[if_idx] : IF_pc_i + 32'd4;
    end

    assign id_idx = ID_pc_i[IDX_WIDTH+1:2];
    assign id_tag = ID_pc_i[31:IDX_WIDTH+2];
    assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);

    logic       upd_acc;
    logic       ent_we;
    logic       ent_is_jal;
    logic       valid_clr;
    logic       ctr_we;
    logic [1:0] ctr_wdata;
    logic       is_ctrl;
    logic       is_mis;

    // rst is deliberately left out here: the reset branch of the valid and
    // counter flops overrides, and data-array writes land in invalid entries.
    assign upd_acc = ID_update_i & ~ID_stall_i;

    always_comb begin
        ent_we     = 1'b0;
        ent_is_jal = 1'b0;
        valid_clr  = 1'b0;
        ctr_we     = 1'b0;
        ctr_wdata  = 2'b00;
        is_ctrl    = 1'b0;
        is_mis     = 1'b0;
        if (upd_acc) begin
            case (ID_opcode_i)
                op_br: begin
                    is_ctrl = 1'b1;
                    is_mis  = ID_taken_i ^ ID_pred_i;
                    if (id_hit) begin
                        ctr_we = 1'b1;
                        if (ID_taken_i)
                            ctr_wdata = (ctr_q[id_idx] == 2'b11) ? 2'b11 : ctr_q[id_idx] + 2'd1;
                        else
                            ctr_wdata = (ctr_q[id_idx] == 2'b00) ? 2'b00 : ctr_q[id_idx] - 2'd1;
                    end else if (ID_taken_i) begin
                        ent_we    = 1'b1;
                        ctr_we    = 1'b1;
                        ctr_wdata = 2'b10;
                    end
                end
                op_jal: begin
                    is_ctrl    = 1'b1;
                    is_mis     = ~ID_pred_i;
                    ent_we     = 1'b1;
                    ent_is_jal = 1'b1;
                    ctr_we     = 1'b1;
                    ctr_wdata  = 2'b11;
                end
                op_jalr: begin
                    is_ctrl   = 1'b1;
                    is_mis    = ~ID_pred_i;
                    valid_clr = id_hit;
                end
                default: ;
            endcase
        end
    end

    assign br_cnt_d  = br_cnt_q + {31'd0, is_ctrl};
    assign mis_cnt_d = mis_cnt_q + {31'd0, is_mis};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (ent_we)
                valid_q[id_idx] <= 1'b1;
            else if (valid_clr)
                valid_q[id_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ent_we) begin
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= ID_target_i;
            is_jal_q[id_idx] <= ent_is_jal;
        end
        if (ctr_we)
            ctr_q[id_idx] <= ctr_wdata;
    end

    assign br_count_o      = br_cnt_q;
    assign mispred_count_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a table-of-PCs model.
module tb_branch_predictor;
    import rv32i_types::*;

    localparam int NENT = 32;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_update;
    logic        id_stall;
    rv32i_opcode id_opcode;
    logic [31:0] id_pc;
    logic        id_pred;
    logic        id_taken;
    logic [31:0] id_target;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .IF_pc_i          (if_pc),
        .IF_pred_taken_o  (pred_taken),
        .IF_pred_target_o (pred_target),
        .ID_update_i      (id_update),
        .ID_stall_i       (id_stall),
        .ID_opcode_i      (id_opcode),
        .ID_pc_i          (id_pc),
        .ID_pred_i        (id_pred),
        .ID_taken_i       (id_taken),
        .ID_target_i      (id_target),
        .br_count_o       (br_count),
        .mispred_count_o  (mispred_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: each slot remembers the full PC it belongs to
    bit          m_valid [NENT];
    logic [31:0] m_pc    [NENT];
    logic [31:0] m_tgt   [NENT];
    bit          m_jal   [NENT];
    int          m_ctr   [NENT];
    int unsigned m_br;
    int unsigned m_mis;

    logic [96:0] exp_q[$];
    int checks;
    int failures;
    bit driver_done;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && ((m_pc[s] / 128) == (pc / 128));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) m_valid[i] = 0;
        m_br = 0;
        m_mis = 0;
    endtask

    task automatic m_update(input rv32i_opcode op, input logic [31:0] pc, input bit pr,
                            input bit tk, input logic [31:0] tgt);
        int s = slot(pc);
        bit h = m_hit(pc);
        if (op == op_br) begin
            m_br++;
            if (tk != pr) m_mis++;
            if (h) m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
            else if (tk) begin
                m_valid[s] = 1; m_pc[s] = pc; m_tgt[s] = tgt; m_jal[s] = 0; m_ctr[s] = 2;
            end
        end else if (op == op_jal) begin
            m_br++;
            if (!pr) m_mis++;
            m_valid[s] = 1; m_pc[s] = pc; m_tgt[s] = tgt; m_jal[s] = 1; m_ctr[s] = 3;
        end else if (op == op_jalr) begin
            m_br++;
            if (!pr) m_mis++;
            if (h) m_valid[s] = 0;
        end
    endtask

    // driver: one call per cycle, inputs change on the falling edge
    task automatic drive_cycle(input logic [31:0] lpc, input bit upd, input bit stl,
                               input rv32i_opcode op, input logic [31:0] upc, input bit pr,
                               input bit tk, input logic [31:0] tgt, input bit rst_v);
        bit e_pred;
        logic [31:0] e_tgt;
        @(negedge clk);
        rst = rst_v; if_pc = lpc; id_update = upd; id_stall = stl; id_opcode = op;
        id_pc = upc; id_pred = pr; id_taken = tk; id_target = tgt;
        if (rst_v) m_reset();
        e_pred = m_hit(lpc) && (m_jal[slot(lpc)] || m_ctr[slot(lpc)] >= 2);
        e_tgt  = e_pred ? m_tgt[slot(lpc)] : lpc + 32'd4;
        exp_q.push_back({e_pred, e_tgt, m_br, m_mis});
        if (!rst_v && upd && !stl) m_update(op, upc, pr, tk, tgt);
    endtask

    task automatic look(input logic [31:0] lpc);
        drive_cycle(lpc, 0, 0, op_imm, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic upd(input logic [31:0] lpc, input rv32i_opcode op, input logic [31:0] upc,
                       input bit pr, input bit tk, input logic [31:0] tgt);
        drive_cycle(lpc, 1, 0, op, upc, pr, tk, tgt, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi = ($urandom_range(0, 3) == 0) ? 32'h1000_0000 : 32'h0;
        return hi | (32'($urandom_range(0, 95)) << 2);
    endfunction

    function automatic rv32i_opcode rand_op();
        case ($urandom_range(0, 4))
            0, 1:    return op_br;
            2:       return op_jal;
            3:       return op_jalr;
            default: return op_imm;
        endcase
    endfunction

    // monitor / scoreboard
    initial begin
        logic [96:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if (pred_taken !== e[96]) begin
                    failures++;
                    $display("FAIL pred_taken pc=%h got=%b exp=%b", if_pc, pred_taken, e[96]);
                end
                if (pred_target !== e[95:64]) begin
                    failures++;
                    $display("FAIL pred_target pc=%h got=%h exp=%h", if_pc, pred_target, e[95:64]);
                end
                if (br_count !== e[63:32]) begin
                    failures++;
                    $display("FAIL br_count got=%0d exp=%0d", br_count, e[63:32]);
                end
                if (mispred_count !== e[31:0]) begin
                    failures++;
                    $display("FAIL mispred_count got=%0d exp=%0d", mispred_count, e[31:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] p;
        checks = 0; failures = 0; driver_done = 0;
        rst = 1'b1; if_pc = '0; id_update = 0; id_stall = 0; id_opcode = op_imm;
        id_pc = '0; id_pred = 0; id_taken = 0; id_target = '0;
        m_reset();
        for (int i = 0; i < NENT; i++) begin m_ctr[i] = 0; m_jal[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; end

        drive_cycle(32'h60, 0, 0, op_imm, 0, 0, 0, 0, 1);
        look(32'h60);
        upd(32'h80, op_br, 32'h80, 0, 1, 32'h40);      // same-cycle lookup sees old entry
        upd(32'h80, op_br, 32'h80, 1, 0, 32'h40);
        upd(32'h80, op_br, 32'h80, 0, 1, 32'h40);
        upd(32'h80, op_br, 32'h80, 1, 1, 32'h40);
        upd(32'h80, op_br, 32'h80, 1, 1, 32'h40);
        upd(32'h80, op_br, 32'h80, 1, 0, 32'h40);
        look(32'h80);
        upd(32'h100, op_jal, 32'h80, 0, 1, 32'h200);
        look(32'h80);
        upd(32'h100, op_jal, 32'h100, 0, 1, 32'h300);
        look(32'h80);
        look(32'h100);
        upd(32'h100, op_jalr, 32'h100, 1, 1, 32'h500);
        look(32'h100);
        upd(32'h80, op_jal, 32'h80, 1, 1, 32'h280);
        for (int i = 0; i < 3; i++) drive_cycle(32'h80, 1, 1, op_br, 32'h80, 0, 0, 32'h0, 0);
        drive_cycle(32'h80, 1, 1, op_jalr, 32'h80, 0, 0, 32'h0, 0);
        look(32'h80);
        drive_cycle(32'h80, 1, 0, op_jal, 32'h84, 0, 1, 32'h900, 1);  // async reset, update dropped
        look(32'h80);
        look(32'h84);

        for (int i = 0; i < 600; i++) begin
            p = rand_pc();
            drive_cycle(($urandom_range(0, 3) == 0) ? p : rand_pc(),
                        $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, rand_op(),
                        p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        32'($urandom_range(0, 32'h0fff_ffff)) & 32'hffff_fffc,
                        $urandom_range(0, 199) == 0);
        end
        driver_done = 1;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
